// File: rtl/io_registers.sv
// IO register block: vblank status/interrupt and serial game controller polling.
// Reads are side-effect free; controller bytes only change at the end of a poll.
module io_registers #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_vblank_i,
  input  logic       cpu_wen_i,
  input  logic       SELECT_in_vblank_i,
  input  logic       SELECT_clr_vblank_irq_i,
  input  logic       SELECT_controller_1_i,
  input  logic       SELECT_controller_2_i,
  output logic [7:0] cpu_rdata_o,
  output logic       rdata_valid_o,
  output logic       vblank_irq_o,
  output logic       ctrl_latch_o,
  output logic       ctrl_clk_o,
  input  logic       ctrl_1_data_i,
  input  logic       ctrl_2_data_i,
  output logic       poll_busy_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] BIT_LO = 3'd2;
  localparam logic [2:0] BIT_HI = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  // vblank edge detection and interrupt state
  logic              vblank_q;
  logic              hist_armed;
  logic              vblank_rise;
  logic              irq_clr;
  logic              irq_pending;

  // controller input synchronizers
  logic [1:0]        sync_1_q;
  logic [1:0]        sync_2_q;
  logic              data_1;
  logic              data_2;

  // poll FSM and datapath
  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [BYTE_W-1:0] shift_1_q;
  logic [BYTE_W-1:0] shift_1_d;
  logic [BYTE_W-1:0] shift_2_q;
  logic [BYTE_W-1:0] shift_2_d;
  logic [BYTE_W-1:0] ctrl_1_q;
  logic [BYTE_W-1:0] ctrl_1_d;
  logic [BYTE_W-1:0] ctrl_2_q;
  logic [BYTE_W-1:0] ctrl_2_d;
  logic              cnt_last;
  logic              latch_d;
  logic              clk_d;
  logic              busy_d;

  // An edge is only trusted once the history holds a real sample, so a level
  // already high at reset release is not mistaken for a new vblank.
  assign vblank_rise = in_vblank_i & ~vblank_q & hist_armed;
  assign irq_clr     = cpu_wen_i & SELECT_clr_vblank_irq_i;
  assign data_1      = sync_1_q[1];
  assign data_2      = sync_2_q[1];
  assign cnt_last    = (cnt_q == CNT_LAST);

  // vblank history register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vblank_q   <= 1'b0;
      hist_armed <= 1'b0;
    end else begin
      vblank_q   <= in_vblank_i;
      hist_armed <= 1'b1;
    end
  end

  // Interrupt pending flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_pending <= 1'b0;
    end else if (vblank_rise) begin
      irq_pending <= 1'b1;
    end else if (irq_clr) begin
      irq_pending <= 1'b0;
    end
  end

  // Two-flop synchronizers for the asynchronous controller data pins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_1_q <= 2'b00;
      sync_2_q <= 2'b00;
    end else begin
      sync_1_q <= {sync_1_q[0], ctrl_1_data_i};
      sync_2_q <= {sync_2_q[0], ctrl_2_data_i};
    end
  end

  // Poll FSM state, datapath and registered controller pins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_1_q    <= '0;
      shift_2_q    <= '0;
      ctrl_1_q     <= '0;
      ctrl_2_q     <= '0;
      ctrl_latch_o <= 1'b0;
      ctrl_clk_o   <= 1'b0;
      poll_busy_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_1_q    <= shift_1_d;
      shift_2_q    <= shift_2_d;
      ctrl_1_q     <= ctrl_1_d;
      ctrl_2_q     <= ctrl_2_d;
      ctrl_latch_o <= latch_d;
      ctrl_clk_o   <= clk_d;
      poll_busy_o  <= busy_d;
    end
  end

  // Next-state logic; every state entry restarts the half-period counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_1_d = shift_1_q;
    shift_2_d = shift_2_q;
    ctrl_1_d  = ctrl_1_q;
    ctrl_2_d  = ctrl_2_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (vblank_rise) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (cnt_last) begin
          state_d = BIT_LO;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      BIT_LO: begin
        if (cnt_last) begin
          shift_1_d = {shift_1_q[BYTE_W-2:0], ~data_1};
          shift_2_d = {shift_2_q[BYTE_W-2:0], ~data_2};
          state_d   = BIT_HI;
          cnt_d     = '0;
        end
      end
      BIT_HI: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = COMMIT;
          end else begin
            state_d = BIT_LO;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      COMMIT: begin
        ctrl_1_d = shift_1_q;
        ctrl_2_d = shift_2_q;
        state_d  = IDLE;
        cnt_d    = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin levels follow the next state so they line up with the state register
  always_comb begin
    latch_d = (state_d == LATCH);
    clk_d   = (state_d == BIT_HI);
    busy_d  = (state_d != IDLE);
  end

  // Read mux from registered state; reads never alter anything
  always_comb begin
    cpu_rdata_o = 8'h00;
    if (SELECT_in_vblank_i) begin
      cpu_rdata_o = {7'b0, in_vblank_i};
    end else if (SELECT_clr_vblank_irq_i) begin
      cpu_rdata_o = {7'b0, irq_pending};
    end else if (SELECT_controller_1_i) begin
      cpu_rdata_o = ctrl_1_q;
    end else if (SELECT_controller_2_i) begin
      cpu_rdata_o = ctrl_2_q;
    end
  end

  assign rdata_valid_o = SELECT_in_vblank_i | SELECT_clr_vblank_irq_i |
                         SELECT_controller_1_i | SELECT_controller_2_i;
  assign vblank_irq_o  = irq_pending;

endmodule

// File: tb/tb_io_registers.sv
// Directed bench for io_registers with CLK_DIV=4 and a behavioural
// shift-register controller model on both data pins.
module tb_io_registers;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_vblank = 1'b0;
  logic       cpu_wen = 1'b0;
  logic       sel_vb = 1'b0;
  logic       sel_clr = 1'b0;
  logic       sel_c1 = 1'b0;
  logic       sel_c2 = 1'b0;
  logic [7:0] cpu_rdata;
  logic       rdata_valid;
  logic       vblank_irq;
  logic       ctrl_latch;
  logic       ctrl_clk;
  logic       ctrl_1_data;
  logic       ctrl_2_data;
  logic       poll_busy;

  int total = 0;
  int bad = 0;
  int busy_total = 0;
  int latch_pulses = 0;
  logic latch_prev = 1'b0;
  logic clk_prev = 1'b0;
  logic [3:0] pidx = 4'd8;
  logic [7:0] btn1 = 8'h00;
  logic [7:0] btn2 = 8'h00;

  io_registers #(.CLK_DIV(4)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .in_vblank_i             (in_vblank),
    .cpu_wen_i               (cpu_wen),
    .SELECT_in_vblank_i      (sel_vb),
    .SELECT_clr_vblank_irq_i (sel_clr),
    .SELECT_controller_1_i   (sel_c1),
    .SELECT_controller_2_i   (sel_c2),
    .cpu_rdata_o             (cpu_rdata),
    .rdata_valid_o           (rdata_valid),
    .vblank_irq_o            (vblank_irq),
    .ctrl_latch_o            (ctrl_latch),
    .ctrl_clk_o              (ctrl_clk),
    .ctrl_1_data_i           (ctrl_1_data),
    .ctrl_2_data_i           (ctrl_2_data),
    .poll_busy_o             (poll_busy)
  );

  always #5 clk = ~clk;

  // Controller model: latch reloads the first button, each clock rise advances
  always @(negedge clk) begin
    if (ctrl_latch) pidx <= 4'd0;
    else if (ctrl_clk && !clk_prev && pidx < 4'd8) pidx <= pidx + 4'd1;
    clk_prev <= ctrl_clk;
    if (poll_busy) busy_total <= busy_total + 1;
    if (ctrl_latch && !latch_prev) latch_pulses <= latch_pulses + 1;
    latch_prev <= ctrl_latch;
  end

  assign ctrl_1_data = (pidx < 4'd8) ? ~btn1[3'(4'd7 - pidx)] : 1'b1;
  assign ctrl_2_data = (pidx < 4'd8) ? ~btn2[3'(4'd7 - pidx)] : 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, output logic [7:0] d, output logic v);
    sel_vb  = (a == 0);
    sel_clr = (a == 1);
    sel_c1  = (a == 2);
    sel_c2  = (a == 3);
    #1;
    d = cpu_rdata;
    v = rdata_valid;
    sel_vb  = 1'b0;
    sel_clr = 1'b0;
    sel_c1  = 1'b0;
    sel_c2  = 1'b0;
  endtask

  task automatic wr_clr();
    cpu_wen = 1'b1;
    sel_clr = 1'b1;
    step();
    cpu_wen = 1'b0;
    sel_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (poll_busy && n < 300) begin
      step();
      n++;
    end
    chk("poll_timeout", 8'(poll_busy), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic v;
    logic ok;
    int b0;
    int l0;
    int n;

    // reset state
    step();
    step();
    chk("rst_irq", 8'(vblank_irq), 8'h00);
    chk("rst_latch", 8'(ctrl_latch), 8'h00);
    chk("rst_clk", 8'(ctrl_clk), 8'h00);
    chk("rst_busy", 8'(poll_busy), 8'h00);
    chk("rst_nosel_rdata", cpu_rdata, 8'h00);
    chk("rst_nosel_valid", 8'(rdata_valid), 8'h00);
    rd(2, d, v);
    chk("rst_rd_ctrl1", d, 8'h00);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_irq", 8'(vblank_irq), 8'h00);
    rd(0, d, v);
    chk("rd_vblank_low", d, 8'h00);
    chk("rd_valid", 8'(v), 8'h01);

    // A + Right on controller 1, irq set/clear
    btn1 = 8'h81;
    btn2 = 8'h00;
    b0 = busy_total;
    l0 = latch_pulses;
    in_vblank = 1'b1;
    step();
    chk("irq_set", 8'(vblank_irq), 8'h01);
    chk("poll_start_busy", 8'(poll_busy), 8'h01);
    chk("poll_start_latch", 8'(ctrl_latch), 8'h01);
    rd(1, d, v);
    chk("rd_irq_pending", d, 8'h01);
    rd(0, d, v);
    chk("rd_vblank_high", d, 8'h01);
    wr_clr();
    chk("irq_cleared", 8'(vblank_irq), 8'h00);
    wait_idle();
    chk("busy_len_81", 8'(busy_total - b0), 8'd69);
    chk("latch_pulses_81", 8'(latch_pulses - l0), 8'd1);
    rd(2, d, v);
    chk("ctrl1_81", d, 8'h81);
    rd(3, d, v);
    chk("ctrl2_00", d, 8'h00);

    // set wins over clear, second rise mid-poll
    btn1 = 8'hFF;
    btn2 = 8'h3C;
    in_vblank = 1'b0;
    step();
    step();
    b0 = busy_total;
    l0 = latch_pulses;
    in_vblank = 1'b1;
    cpu_wen = 1'b1;
    sel_clr = 1'b1;
    step();
    cpu_wen = 1'b0;
    sel_clr = 1'b0;
    chk("irq_set_wins", 8'(vblank_irq), 8'h01);
    repeat (5) step();
    wr_clr();
    chk("irq_clr_midpoll", 8'(vblank_irq), 8'h00);
    in_vblank = 1'b0;
    repeat (3) step();
    in_vblank = 1'b1;
    step();
    chk("irq_second_rise", 8'(vblank_irq), 8'h01);
    wait_idle();
    chk("busy_len_norestart", 8'(busy_total - b0), 8'd69);
    chk("latch_pulses_once", 8'(latch_pulses - l0), 8'd1);
    rd(2, d, v);
    chk("ctrl1_ff", d, 8'hFF);
    rd(3, d, v);
    chk("ctrl2_3c", d, 8'h3C);

    // no partial byte visible while polling
    btn1 = 8'h00;
    btn2 = 8'h00;
    in_vblank = 1'b0;
    step();
    in_vblank = 1'b1;
    sel_c1 = 1'b1;
    ok = 1'b1;
    n = 0;
    step();
    while (poll_busy && n < 300) begin
      if (cpu_rdata !== 8'hFF) ok = 1'b0;
      step();
      n++;
    end
    chk("stale_during_poll", 8'(ok), 8'h01);
    chk("poll_busy_done", 8'(poll_busy), 8'h00);
    chk("commit_ctrl1_00", cpu_rdata, 8'h00);
    sel_c1 = 1'b0;

    // reset in BIT_HI of bit 3
    btn1 = 8'h5A;
    btn2 = 8'hA5;
    in_vblank = 1'b0;
    step();
    in_vblank = 1'b1;
    step();
    wait_idle();
    rd(2, d, v);
    chk("ctrl1_5a", d, 8'h5A);
    rd(3, d, v);
    chk("ctrl2_a5", d, 8'hA5);
    in_vblank = 1'b0;
    step();
    in_vblank = 1'b1;
    step();
    repeat (33) step();
    chk("bit3_hi_clk", 8'(ctrl_clk), 8'h01);
    rst = 1'b1;
    #1;
    chk("abort_irq", 8'(vblank_irq), 8'h00);
    chk("abort_latch", 8'(ctrl_latch), 8'h00);
    chk("abort_clk", 8'(ctrl_clk), 8'h00);
    chk("abort_busy", 8'(poll_busy), 8'h00);
    rd(2, d, v);
    chk("abort_ctrl1", d, 8'h00);
    rd(3, d, v);
    chk("abort_ctrl2", d, 8'h00);
    step();
    step();
    rst = 1'b0;
    b0 = busy_total;
    repeat (100) step();
    chk("no_poll_after_rst", 8'(busy_total - b0), 8'h00);
    chk("no_irq_high_level", 8'(vblank_irq), 8'h00);
    rd(2, d, v);
    chk("ctrl1_still_00", d, 8'h00);
    in_vblank = 1'b0;
    step();
    in_vblank = 1'b1;
    step();
    chk("irq_after_new_rise", 8'(vblank_irq), 8'h01);
    chk("poll_after_new_rise", 8'(poll_busy), 8'h01);
    wait_idle();
    rd(2, d, v);
    chk("ctrl1_5a_again", d, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
